// File: rtl/t_frame_sequencer.sv
// Frame sequencer: streams one FFT frame from BRAM into the T(0,i) block and counts its output beats.
// Optional checking (beat address check + drain timeout) is enabled by defining T_SEQ_CHECK_EN.
module t_frame_sequencer #(
    parameter int BIT_WIDTH     = 32,
    parameter int I             = 160,
    parameter int BRAM_LATENCY  = 2,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_ready,
    output logic [$clog2(I)-1:0]  fft_rd_addr,
    input  logic [BIT_WIDTH-1:0]  fft_rd_data,
    output logic                  t_valid,
    output logic [BIT_WIDTH-1:0]  t_data,
    input  logic                  t_out_valid,
    input  logic [$clog2(I)-1:0]  t_out_addr,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  overrun,
    input  logic                  clear_overrun,
    output logic                  seq_error
);
    localparam int AW = $clog2(I);
    localparam int CW = $clog2(I + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [BRAM_LATENCY-1:0] strb_q, strb_d;
    logic                    t_valid_q, t_valid_d;
    logic [BIT_WIDTH-1:0]    t_data_q, t_data_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    started_q, started_d;
    logic                    pending_q, pending_d;
    logic                    overrun_q, overrun_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic                    rd_strobe;
    logic                    ovr_event;
    logic                    beat;

`ifdef T_SEQ_CHECK_EN
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          seq_error_q, seq_error_d;
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        started_d     = started_q;
        pending_d     = pending_q;
        frame_count_d = frame_count_q;
        ovr_event     = 1'b0;
        rd_strobe     = (state_q == S_FETCH);
        strb_d[0]     = rd_strobe;
        for (int k = 1; k < BRAM_LATENCY; k++) begin
            strb_d[k] = strb_q[k-1];
        end
        t_valid_d = strb_q[BRAM_LATENCY-1];
        t_data_d  = strb_q[BRAM_LATENCY-1] ? fft_rd_data : t_data_q;
`ifdef T_SEQ_CHECK_EN
        seq_error_d = seq_error_q;
        tmo_d       = t_valid_q ? '0 : ((tmo_q == TW'(DRAIN_TIMEOUT)) ? tmo_q : tmo_q + 1'b1);
`endif
        // Output beats only belong to this frame once its burst has begun.
        beat = t_out_valid && (started_q || t_valid_q);
        if (t_valid_q) begin
            started_d = 1'b1;
        end
        if (beat && (cnt_q != CW'(I))) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (frame_ready && (state_q != S_IDLE)) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else begin
                ovr_event = 1'b1;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (frame_ready || pending_q) begin
                    state_d   = S_FETCH;
                    pending_d = pending_q && frame_ready;
                    addr_d    = '0;
                    cnt_d     = '0;
                    started_d = 1'b0;
                end
            end
            S_FETCH: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == AW'(I - 1)) begin
                    addr_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (strb_q == '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
`ifdef T_SEQ_CHECK_EN
                if (beat && (cnt_q != CW'(I)) && (CW'(t_out_addr) != cnt_q)) begin
                    seq_error_d = 1'b1;
                end
`endif
                if (cnt_q == CW'(I)) begin
                    state_d = S_DONE;
`ifdef T_SEQ_CHECK_EN
                end else if (tmo_q == TW'(DRAIN_TIMEOUT)) begin
                    state_d     = S_DONE;
                    seq_error_d = 1'b1;
`endif
                end
            end
            S_DONE: begin
                frame_count_d = frame_count_q + 1'b1;
                cnt_d         = '0;
                started_d     = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        overrun_d = (overrun_q && !clear_overrun) || ovr_event;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            strb_q        <= '0;
            t_valid_q     <= 1'b0;
            t_data_q      <= '0;
            cnt_q         <= '0;
            started_q     <= 1'b0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            strb_q        <= strb_d;
            t_valid_q     <= t_valid_d;
            t_data_q      <= t_data_d;
            cnt_q         <= cnt_d;
            started_q     <= started_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef T_SEQ_CHECK_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tmo_q       <= '0;
            seq_error_q <= 1'b0;
        end else begin
            tmo_q       <= tmo_d;
            seq_error_q <= seq_error_d;
        end
    end
    assign seq_error = seq_error_q;
`else
    assign seq_error = 1'b0;
`endif

    assign fft_rd_addr = addr_q;
    assign t_valid     = t_valid_q;
    assign t_data      = t_data_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = (state_q == S_DONE);
    assign frame_count = frame_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_t_frame_sequencer.sv
// Bench for t_frame_sequencer: ramp BRAM model, T block model, t_data scoreboard and scenario table.
module tb_t_frame_sequencer;
    localparam int BW  = 32;
    localparam int I   = 160;
    localparam int LAT = 2;
    localparam int AW  = $clog2(I);

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          frame_ready = 1'b0;
    logic [AW-1:0] fft_rd_addr;
    logic [BW-1:0] fft_rd_data;
    logic          t_valid;
    logic [BW-1:0] t_data;
    logic          t_out_valid = 1'b0;
    logic [AW-1:0] t_out_addr = '0;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          overrun;
    logic          clear_overrun = 1'b0;
    logic          seq_error;

    t_frame_sequencer #(.BIT_WIDTH(BW), .I(I), .BRAM_LATENCY(LAT), .DRAIN_TIMEOUT(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_ready(frame_ready),
        .fft_rd_addr(fft_rd_addr), .fft_rd_data(fft_rd_data),
        .t_valid(t_valid), .t_data(t_data),
        .t_out_valid(t_out_valid), .t_out_addr(t_out_addr),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .overrun(overrun), .clear_overrun(clear_overrun), .seq_error(seq_error)
    );

    always #5 clk_in = ~clk_in;

    // BRAM: registered address pipeline, LAT cycles of latency
    logic [AW-1:0] rd_pipe [LAT];
    always @(posedge clk_in) begin
        rd_pipe[0] <= fft_rd_addr;
        for (int j = 1; j < LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign fft_rd_data = 32'hA500_0000 | 32'(rd_pipe[LAT-1]);

    int n_vec = 0;
    int n_err = 0;
    logic [BW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int k = 0; k < I; k++) exp_q.push_back(32'hA500_0000 | 32'(k));
    endtask

    // Monitor + T block model, both evaluated on the falling edge
    int cyc = 0, fetch_cyc = 0, blen = 0, gap = 0, tin = 0, done_cnt = 0;
    int emit_left = 0, emit_idx = 0, t_mode = 0;
    bit in_burst = 0, had_burst = 0, busy_prev = 0;
    always @(negedge clk_in) begin
        cyc++;
        if (!rst_in) begin
            blen = 0; in_burst = 0; had_burst = 0; tin = 0; gap = 0;
            emit_left = 0; emit_idx = 0; busy_prev = 0;
            t_out_valid = 1'b0; t_out_addr = '0;
        end else begin
            if (busy && !busy_prev) fetch_cyc = cyc;
            busy_prev = busy;
            if (frame_done) done_cnt++;
            if (t_valid) begin
                if (!in_burst) begin
                    chk("first_valid_latency", 64'(cyc - fetch_cyc), 64'(LAT + 1));
                    if (had_burst) chk("gap_ge4", 64'(gap >= 4), 64'd1);
                    in_burst = 1; blen = 0;
                end
                blen++;
                if (exp_q.size() == 0) chk("t_data_unexpected", 64'(t_data), 64'hDEAD);
                else chk("t_data", 64'(t_data), 64'(exp_q.pop_front()));
                tin++;
            end else begin
                if (in_burst) begin
                    chk("burst_len", 64'(blen), 64'(I));
                    in_burst = 0; had_burst = 1; gap = 0;
                end
                gap++;
                if (tin == I) begin emit_left = I; emit_idx = 0; end
                tin = 0;
            end
            if (emit_left > 0 && !(t_mode == 2 && emit_idx == 100)) begin
                t_out_valid = 1'b1;
                t_out_addr  = AW'((t_mode == 1 && emit_idx >= 57) ? emit_idx + 1 : emit_idx);
                emit_idx++; emit_left--;
            end else begin
                t_out_valid = 1'b0;
                if (t_mode == 2) emit_left = 0;
            end
        end
    end

    task automatic pulse();
        frame_ready = 1'b1;
        @(negedge clk_in);
        frame_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int k = 0; k < 5000 && quiet < 4; k++) begin
            @(negedge clk_in);
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 4) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_in); #2;
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1'b1;
        exp_q.delete();
    endtask

    typedef struct {
        int n_pulses;
        int spacing;
        bit clr;
        int exp_frames;
        bit exp_ovr;
    } vec_t;
    vec_t vecs [5];

    initial begin
        int exp_fc = 0;
        int d0;
        bit seen;
        vecs[0] = '{1, 0,  0, 1, 0};
        vecs[1] = '{2, 20, 0, 2, 0};
        vecs[2] = '{3, 20, 0, 2, 1};
        vecs[3] = '{1, 0,  1, 1, 0};
        vecs[4] = '{3, 5,  0, 2, 1};

        #1;
        chk("rst_t_valid", 64'(t_valid), 64'd0);
        chk("rst_t_data", 64'(t_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_seq_error", 64'(seq_error), 64'd0);
        chk("rst_rd_addr", 64'(fft_rd_addr), 64'd0);
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1'b1;
        @(negedge clk_in);

        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt;
            if (vecs[v].clr) begin
                clear_overrun = 1'b1;
                @(negedge clk_in);
                clear_overrun = 1'b0;
            end
            for (int f = 0; f < vecs[v].exp_frames; f++) push_frame();
            for (int p = 0; p < vecs[v].n_pulses; p++) begin
                pulse();
                repeat (vecs[v].spacing) @(negedge clk_in);
            end
            wait_idle();
            exp_fc += vecs[v].exp_frames;
            chk("vec_frame_count", 64'(frame_count), 64'(exp_fc));
            chk("vec_done_pulses", 64'(done_cnt - d0), 64'(vecs[v].exp_frames));
            chk("vec_overrun", 64'(overrun), 64'(vecs[v].exp_ovr));
            chk("vec_queue_empty", 64'(exp_q.size()), 64'd0);
            chk("vec_busy", 64'(busy), 64'd0);
        end

        // clear_overrun alone, then overrun event coinciding with clear (set wins)
        clear_overrun = 1'b1;
        @(negedge clk_in);
        clear_overrun = 1'b0;
        chk("clear_overrun", 64'(overrun), 64'd0);
        push_frame(); push_frame();
        pulse();
        repeat (20) @(negedge clk_in);
        pulse();
        repeat (20) @(negedge clk_in);
        clear_overrun = 1'b1;
        pulse();
        clear_overrun = 1'b0;
        chk("set_wins_overrun", 64'(overrun), 64'd1);
        clear_overrun = 1'b1;
        @(negedge clk_in);
        clear_overrun = 1'b0;
        chk("clear_after_set", 64'(overrun), 64'd0);
        wait_idle();
        exp_fc += 2;
        chk("setwin_frame_count", 64'(frame_count), 64'(exp_fc));

        // frame_ready landing exactly in the DONE cycle
        d0 = done_cnt;
        push_frame(); push_frame();
        pulse();
        seen = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk_in);
            seen = frame_done;
        end
        if (!seen) chk("done_cycle_timeout", 64'd0, 64'd1);
        pulse();
        wait_idle();
        exp_fc += 2;
        chk("done_cycle_frame_count", 64'(frame_count), 64'(exp_fc));
        chk("done_cycle_pulses", 64'(done_cnt - d0), 64'd2);
        chk("done_cycle_overrun", 64'(overrun), 64'd0);

        // asynchronous reset at burst beat 80
        d0 = done_cnt;
        push_frame();
        pulse();
        seen = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk_in); #2;
            seen = (blen >= 80);
        end
        if (!seen) chk("beat80_timeout", 64'd0, 64'd1);
        rst_in = 1'b0;
        #1;
        chk("midrst_t_valid", 64'(t_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_t_data", 64'(t_data), 64'd0);
        chk("midrst_frame_count", 64'(frame_count), 64'd0);
        chk("midrst_rd_addr", 64'(fft_rd_addr), 64'd0);
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1'b1;
        exp_q.delete();
        repeat (4) @(negedge clk_in);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        push_frame();
        pulse();
        wait_idle();
        chk("postrst_frame_count", 64'(frame_count), 64'd1);
        chk("postrst_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("seq_error_quiet", 64'(seq_error), 64'd0);

`ifdef T_SEQ_CHECK_EN
        t_mode = 1;
        push_frame();
        pulse();
        wait_idle();
        chk("skip57_seq_error", 64'(seq_error), 64'd1);
        do_reset();
        @(negedge clk_in);
        t_mode = 2;
        d0 = done_cnt;
        push_frame();
        pulse();
        wait_idle();
        chk("stall_seq_error", 64'(seq_error), 64'd1);
        chk("stall_done_pulse", 64'(done_cnt - d0), 64'd1);
        chk("stall_frame_count", 64'(frame_count), 64'd1);
        t_mode = 0;
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
